// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: TAP FSM, instruction/bypass registers, TDO mux and boundary-scan controls.
// Optional macro JTAG_IDCODE_EN adds a 32-bit IDCODE data register and makes IDCODE the reset instruction.
module tap_controller #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                TDO,
    output logic                TDO_en,
    output logic                shiftDR,
    output logic                clockDR,
    output logic                updateDR,
    output logic                mode,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] instr
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
`ifdef JTAG_IDCODE_EN
    localparam int unsigned         ID_WIDTH   = 32;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] RST_INSTR  = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] RST_INSTR  = OP_BYPASS;
`endif

    // Elaboration-time parameter sanity checks.
    if (IR_WIDTH < 2) begin : g_bad_ir_width
        $error("tap_controller: IR_WIDTH must be >= 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("tap_controller: IDCODE_VAL bit 0 must be 1");
    end

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                byp_q, byp_d;
    logic                mode_q, mode_d;
    logic                bsr_sel_q, bsr_sel_d;
    logic                sh_dr_q, sh_dr_d;
    logic                sh_ir_q, sh_ir_d;
    logic                shift_dr_q, shift_dr_d;
    logic                cdr_en_q, cdr_en_d;
    logic                udr_en_q, udr_en_d;
    logic                tdo_en_q, tdo_en_d;
`ifdef JTAG_IDCODE_EN
    logic [ID_WIDTH-1:0] idc_q, idc_d;
    logic                idc_sel_q, idc_sel_d;
`endif

    // State and datapath registers; TRST aborts any scan but leaves the BS cells alone.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q    <= TLR;
            instr_q    <= RST_INSTR;
            ir_sr_q    <= '0;
            byp_q      <= 1'b0;
            mode_q     <= 1'b0;
            bsr_sel_q  <= 1'b0;
            sh_dr_q    <= 1'b0;
            sh_ir_q    <= 1'b0;
            shift_dr_q <= 1'b0;
            cdr_en_q   <= 1'b0;
            udr_en_q   <= 1'b0;
            tdo_en_q   <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idc_q      <= '0;
            idc_sel_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            ir_sr_q    <= ir_sr_d;
            byp_q      <= byp_d;
            mode_q     <= mode_d;
            bsr_sel_q  <= bsr_sel_d;
            sh_dr_q    <= sh_dr_d;
            sh_ir_q    <= sh_ir_d;
            shift_dr_q <= shift_dr_d;
            cdr_en_q   <= cdr_en_d;
            udr_en_q   <= udr_en_d;
            tdo_en_q   <= tdo_en_d;
`ifdef JTAG_IDCODE_EN
            idc_q      <= idc_d;
            idc_sel_q  <= idc_sel_d;
`endif
        end
    end

    // Next state, register actions of the current state, and next-cycle control flags.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ir_sr_d = ir_sr_q;
        byp_d   = byp_q;
`ifdef JTAG_IDCODE_EN
        idc_d   = idc_q;
`endif

        unique case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
            PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
            PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase

        unique case (state_q)
            TLR:    instr_d = RST_INSTR;
            CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
            SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            UPD_IR: instr_d = ir_sr_q;
            CAP_DR: begin
                byp_d = 1'b0;
`ifdef JTAG_IDCODE_EN
                idc_d = IDCODE_VAL;
`endif
            end
            SH_DR: begin
                byp_d = TDI;
`ifdef JTAG_IDCODE_EN
                idc_d = {TDI, idc_q[ID_WIDTH-1:1]};
`endif
            end
            default: ;
        endcase

        // Flags are decoded from next state so the gated clocks come straight from flops.
        bsr_sel_d  = (instr_d == OP_EXTEST) || (instr_d == OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
        idc_sel_d  = (instr_d == OP_IDCODE);
`endif
        mode_d     = (instr_d == OP_EXTEST);
        sh_dr_d    = (state_d == SH_DR);
        sh_ir_d    = (state_d == SH_IR);
        shift_dr_d = bsr_sel_d && sh_dr_d;
        cdr_en_d   = bsr_sel_d && ((state_d == CAP_DR) || (state_d == SH_DR));
        udr_en_d   = bsr_sel_d && (state_d == UPD_DR);
        tdo_en_d   = sh_dr_d || sh_ir_d;
    end

    // Serial out: IR LSB in SH_IR, selected data register in SH_DR, otherwise 0.
    logic dr_tdo;
    always_comb begin
        dr_tdo = byp_q;
`ifdef JTAG_IDCODE_EN
        if (idc_sel_q) begin
            dr_tdo = idc_q[0];
        end
`endif
        if (bsr_sel_q) begin
            dr_tdo = bsr_tdo;
        end
    end

    assign TDO       = sh_ir_q ? ir_sr_q[0] : (sh_dr_q ? dr_tdo : 1'b0);
    assign TDO_en    = tdo_en_q;
    assign shiftDR   = shift_dr_q;
    assign clockDR   = ~TCK & cdr_en_q;
    assign updateDR  = ~TCK & udr_en_q;
    assign mode      = mode_q;
    assign tap_state = state_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_tap_controller.sv
// Directed testbench for tap_controller with an 8-cell boundary-scan chain model.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       TRST, TMS, TDI, bsr_tdo;
    logic       TDO, TDO_en, shiftDR, clockDR, updateDR, mode;
    logic [3:0] tap_state;
    logic [3:0] instr;

    int tests = 0;
    int fails = 0;
    int cdr_cnt = 0;
    int udr_cnt = 0;

    logic [7:0] bs_ff, bs_upd, bs_in;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_INSTR = 4'h2;
`else
    localparam logic [3:0] RST_INSTR = 4'hF;
`endif

    tap_controller dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
        .TDO(TDO), .TDO_en(TDO_en), .shiftDR(shiftDR), .clockDR(clockDR),
        .updateDR(updateDR), .mode(mode), .tap_state(tap_state), .instr(instr)
    );

    always #5 TCK = ~TCK;

    // Boundary-scan chain: TDI feeds cell 0, cell 7 drives bsr_tdo.
    always @(posedge clockDR) begin
        cdr_cnt <= cdr_cnt + 1;
        if (shiftDR) bs_ff <= {bs_ff[6:0], TDI};
        else         bs_ff <= bs_in;
    end
    always @(posedge updateDR) begin
        udr_cnt <= udr_cnt + 1;
        bs_upd  <= bs_ff;
    end
    assign bsr_tdo = bs_ff[7];

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] op);
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1, 0);
        step(0, 0);
    endtask

    task automatic test_reset;
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bs_in = 8'h00;
        #2 TRST = 1'b1;
        #1;
        tests++; if (tap_state !== 4'hF) begin fails++; $display("FAIL reset_state got %h exp F", tap_state); end
        tests++; if (instr !== RST_INSTR) begin fails++; $display("FAIL reset_instr got %h exp %h", instr, RST_INSTR); end
        tests++; if ({mode, shiftDR, clockDR, updateDR} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got %b exp 0000", {mode, shiftDR, clockDR, updateDR}); end
        tests++; if ({TDO, TDO_en} !== 2'b00) begin fails++; $display("FAIL reset_tdo got %b exp 00", {TDO, TDO_en}); end
        @(posedge TCK); #1;
        TRST = 1'b0;
        step(1, 0);
        tests++; if (tap_state !== 4'hF) begin fails++; $display("FAIL reset_hold got %h exp F", tap_state); end
    endtask

    task automatic test_tms_walk;
        step(0, 0);
        tests++; if (tap_state !== 4'hC) begin fails++; $display("FAIL walk_rti got %h exp C", tap_state); end
        step(1, 0);
        tests++; if (tap_state !== 4'h7) begin fails++; $display("FAIL walk_seldr got %h exp 7", tap_state); end
        step(0, 0);
        tests++; if (tap_state !== 4'h6) begin fails++; $display("FAIL walk_capdr got %h exp 6", tap_state); end
        step(0, 0);
        tests++; if (tap_state !== 4'h2) begin fails++; $display("FAIL walk_shdr got %h exp 2", tap_state); end
        for (int i = 0; i < 5; i++) step(1, 0);
        tests++; if (tap_state !== 4'hF) begin fails++; $display("FAIL walk_tlr got %h exp F", tap_state); end
    endtask

    task automatic test_ir_load;
        logic [3:0] cap;
        cap = 4'b0001;
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        tests++; if (tap_state !== 4'hA) begin fails++; $display("FAIL ir_shstate got %h exp A", tap_state); end
        for (int i = 0; i < 4; i++) begin
            tests++; if ({TDO_en, TDO} !== {1'b1, cap[i]}) begin fails++; $display("FAIL ir_tdo[%0d] got %b exp %b", i, {TDO_en, TDO}, {1'b1, cap[i]}); end
            step(i == 3, 1'b0);
        end
        step(1, 0);
        tests++; if (instr !== 4'hF || mode !== 1'b0) begin fails++; $display("FAIL ir_upd_early got instr=%h mode=%b exp F/0", instr, mode); end
        step(0, 0);
        tests++; if (instr !== 4'h0 || mode !== 1'b1) begin fails++; $display("FAIL ir_load got instr=%h mode=%b exp 0/1", instr, mode); end
    endtask

    task automatic test_extest_scan;
        int c0, u0;
        logic [7:0] din;
        din = 8'hA5; bs_in = 8'h3C;
        step(1, 0);
        c0 = cdr_cnt; u0 = udr_cnt;
        step(0, 0);
        step(0, 0);
        tests++; if (shiftDR !== 1'b1) begin fails++; $display("FAIL ext_shiftdr got %b exp 1", shiftDR); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (TDO !== bs_in[7-k]) begin fails++; $display("FAIL ext_tdo[%0d] got %b exp %b", k, TDO, bs_in[7-k]); end
            step(k == 7, din[7-k]);
        end
        tests++; if (cdr_cnt - c0 !== 9) begin fails++; $display("FAIL ext_clockdr got %0d exp 9", cdr_cnt - c0); end
        step(0, 0); step(0, 0);
        tests++; if (tap_state !== 4'h3 || cdr_cnt - c0 !== 9 || TDO_en !== 1'b0) begin fails++; $display("FAIL ext_pause got st=%h cnt=%0d en=%b exp 3/9/0", tap_state, cdr_cnt - c0, TDO_en); end
        step(1, 0); step(1, 0);
        tests++; if (tap_state !== 4'h5 || udr_cnt !== u0) begin fails++; $display("FAIL ext_pre_upd got st=%h upd=%0d exp 5/0", tap_state, udr_cnt - u0); end
        step(0, 0);
        tests++; if (udr_cnt - u0 !== 1) begin fails++; $display("FAIL ext_updatedr got %0d exp 1", udr_cnt - u0); end
        tests++; if ((mode ? bs_upd : bs_in) !== 8'hA5) begin fails++; $display("FAIL ext_bs_op got %h exp a5", mode ? bs_upd : bs_in); end
    endtask

    task automatic test_trst_mid_shift;
        step(1, 0); step(0, 0); step(0, 0);
        tests++; if (shiftDR !== 1'b1 || mode !== 1'b1) begin fails++; $display("FAIL trst_pre got sh=%b mode=%b exp 1/1", shiftDR, mode); end
        TRST = 1'b1;
        #1;
        tests++; if (tap_state !== 4'hF || instr !== RST_INSTR) begin fails++; $display("FAIL trst_state got st=%h instr=%h exp F/%h", tap_state, instr, RST_INSTR); end
        tests++; if ({mode, shiftDR, updateDR, TDO_en, TDO} !== 5'b0) begin fails++; $display("FAIL trst_ctrl got %b exp 00000", {mode, shiftDR, updateDR, TDO_en, TDO}); end
        #5;
        tests++; if (clockDR !== 1'b0) begin fails++; $display("FAIL trst_clockdr got %b exp 0", clockDR); end
        @(posedge TCK); #1;
        TRST = 1'b0;
    endtask

    task automatic test_tlr_reload;
        load_ir(4'h0);
        tests++; if (instr !== 4'h0 || mode !== 1'b1) begin fails++; $display("FAIL tlr_pre got instr=%h mode=%b exp 0/1", instr, mode); end
        step(1, 0); step(1, 0); step(1, 0);
        tests++; if (tap_state !== 4'hF || instr !== 4'h0) begin fails++; $display("FAIL tlr_enter got st=%h instr=%h exp F/0", tap_state, instr); end
        step(1, 0);
        tests++; if (instr !== RST_INSTR || mode !== 1'b0) begin fails++; $display("FAIL tlr_reload got instr=%h mode=%b exp %h/0", instr, mode, RST_INSTR); end
    endtask

    task automatic test_sample;
        int c0, u0;
        load_ir(4'h1);
        tests++; if (instr !== 4'h1 || mode !== 1'b0) begin fails++; $display("FAIL smp_instr got instr=%h mode=%b exp 1/0", instr, mode); end
        step(1, 0);
        c0 = cdr_cnt; u0 = udr_cnt;
        step(0, 0); step(0, 0);
        tests++; if (shiftDR !== 1'b1) begin fails++; $display("FAIL smp_shiftdr got %b exp 1", shiftDR); end
        step(1, 1); step(1, 0); step(0, 0);
        tests++; if (cdr_cnt - c0 !== 2 || udr_cnt - u0 !== 1) begin fails++; $display("FAIL smp_pulses got cdr=%0d udr=%0d exp 2/1", cdr_cnt - c0, udr_cnt - u0); end
    endtask

    task automatic test_bypass(input logic [3:0] op);
        int c0, u0;
        logic [3:0] pat, exp_tdo;
        pat = 4'b1101; exp_tdo = 4'b1010;
        load_ir(op);
        tests++; if (instr !== op || mode !== 1'b0) begin fails++; $display("FAIL byp_instr_%h got instr=%h mode=%b exp %h/0", op, instr, mode, op); end
        step(1, 0);
        c0 = cdr_cnt; u0 = udr_cnt;
        step(0, 0); step(0, 0);
        tests++; if (shiftDR !== 1'b0 || TDO_en !== 1'b1) begin fails++; $display("FAIL byp_ctrl_%h got sh=%b en=%b exp 0/1", op, shiftDR, TDO_en); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (TDO !== exp_tdo[k]) begin fails++; $display("FAIL byp_tdo_%h[%0d] got %b exp %b", op, k, TDO, exp_tdo[k]); end
            step(k == 3, pat[k]);
        end
        step(1, 0); step(0, 0);
        tests++; if (cdr_cnt !== c0 || udr_cnt !== u0) begin fails++; $display("FAIL byp_pulses_%h got cdr=%0d udr=%0d exp 0/0", op, cdr_cnt - c0, udr_cnt - u0); end
    endtask

`ifdef JTAG_IDCODE_EN
    task automatic test_idcode;
        logic [31:0] idv;
        idv = 32'h1234_5001;
        TRST = 1'b1; #1; TRST = 1'b0;
        @(posedge TCK); #1;
        tests++; if (instr !== 4'h2) begin fails++; $display("FAIL id_instr got %h exp 2", instr); end
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int k = 0; k < 32; k++) begin
            tests++; if (TDO !== idv[k]) begin fails++; $display("FAIL id_tdo[%0d] got %b exp %b", k, TDO, idv[k]); end
            step(k == 31, 1'b0);
        end
        step(1, 0); step(0, 0);
    endtask
`endif

    initial begin
        test_reset;
        test_tms_walk;
        test_ir_load;
        test_extest_scan;
        test_trst_mid_shift;
        test_tlr_reload;
        test_sample;
        test_bypass(4'hF);
        test_bypass(4'h5);
`ifdef JTAG_IDCODE_EN
        test_idcode;
`else
        test_bypass(4'h2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
